// File: rtl/spm_pkg.sv
// spm_pkg: shared constants, opcodes, state encoding and bus selects for RISC_SPM control
package spm_pkg;
    localparam int word_size  = 8;
    localparam int op_size    = 4;
    localparam int state_size = 4;

    typedef enum logic [state_size-1:0] {
        S_IDLE, S_FET1, S_FET2, S_DEC, S_EX1, S_RD1, S_RD2,
        S_WR1, S_WR2, S_BR1, S_BR2, S_HALT
    } state_t;

    localparam logic [op_size-1:0] OP_NOP = 4'h0;
    localparam logic [op_size-1:0] OP_ADD = 4'h1;
    localparam logic [op_size-1:0] OP_SUB = 4'h2;
    localparam logic [op_size-1:0] OP_AND = 4'h3;
    localparam logic [op_size-1:0] OP_NOT = 4'h4;
    localparam logic [op_size-1:0] OP_RD  = 4'h5;
    localparam logic [op_size-1:0] OP_WR  = 4'h6;
    localparam logic [op_size-1:0] OP_BR  = 4'h7;
    localparam logic [op_size-1:0] OP_BRZ = 4'h8;
    localparam logic [op_size-1:0] OP_HLT = 4'hF;

    localparam logic [2:0] SEL1_PC   = 3'd4;
    localparam logic [1:0] SEL2_ALU  = 2'd0;
    localparam logic [1:0] SEL2_BUS1 = 2'd1;
    localparam logic [1:0] SEL2_MEM  = 2'd2;
endpackage

// File: rtl/spm_control_unit.sv
// spm_control_unit: fetch/decode/execute sequencer driving the RISC_SPM datapath and SRAM
module spm_control_unit
    import spm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [word_size-1:0] instruction,
    input  logic                 zero,
    output logic [3:0]           load_r,
    output logic                 load_pc,
    output logic                 inc_pc,
    output logic                 load_ir,
    output logic                 load_add_r,
    output logic                 load_reg_y,
    output logic                 load_reg_z,
    output logic [2:0]           sel_bus_1,
    output logic [1:0]           sel_bus_2,
    output logic                 write,
    output logic                 halted
);
    state_t state_q, state_d;
    logic [op_size-1:0] opcode;
    logic [1:0] src, dest;

    assign opcode = instruction[word_size-1 -: op_size];
    assign src    = instruction[3:2];
    assign dest   = instruction[1:0];

    // State register; reset drops straight to idle so no write survives mid-instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next state and all datapath controls, decoded from state and the IR
    always_comb begin
        state_d    = state_q;
        load_r     = 4'b0000;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel_bus_1  = 3'd0;
        sel_bus_2  = 2'd0;
        write      = 1'b0;
        halted     = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FET1;
            S_FET1: begin
                sel_bus_1  = SEL1_PC;
                sel_bus_2  = SEL2_BUS1;
                load_add_r = 1'b1;
                state_d    = S_FET2;
            end
            S_FET2: begin
                sel_bus_2 = SEL2_MEM;
                load_ir   = 1'b1;
                inc_pc    = 1'b1;
                state_d   = S_DEC;
            end
            S_DEC: begin
                case (opcode)
                    OP_NOP: state_d = S_FET1;
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel_bus_1  = {1'b0, src};
                        sel_bus_2  = SEL2_BUS1;
                        load_reg_y = 1'b1;
                        state_d    = S_EX1;
                    end
                    OP_NOT: begin
                        sel_bus_1    = {1'b0, src};
                        sel_bus_2    = SEL2_ALU;
                        load_reg_z   = 1'b1;
                        load_r[dest] = 1'b1;
                        state_d      = S_FET1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        sel_bus_1  = SEL1_PC;
                        sel_bus_2  = SEL2_BUS1;
                        load_add_r = 1'b1;
                        state_d    = opcode == OP_RD ? S_RD1 : opcode == OP_WR ? S_WR1 : S_BR1;
                    end
                    OP_BRZ: begin
                        // Untaken branch must still step the PC over the address word
                        sel_bus_1  = zero ? SEL1_PC : 3'd0;
                        sel_bus_2  = zero ? SEL2_BUS1 : 2'd0;
                        load_add_r = zero;
                        inc_pc     = !zero;
                        state_d    = zero ? S_BR1 : S_FET1;
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_EX1: begin
                sel_bus_1    = {1'b0, dest};
                sel_bus_2    = SEL2_ALU;
                load_reg_z   = 1'b1;
                load_r[dest] = 1'b1;
                state_d      = S_FET1;
            end
            S_RD1, S_WR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
                state_d    = state_q == S_RD1 ? S_RD2 : S_WR2;
            end
            S_RD2: begin
                sel_bus_2    = SEL2_MEM;
                load_r[dest] = 1'b1;
                state_d      = S_FET1;
            end
            S_WR2: begin
                sel_bus_1 = {1'b0, src};
                write     = 1'b1;
                state_d   = S_FET1;
            end
            S_BR1: begin
                sel_bus_2  = SEL2_MEM;
                load_add_r = 1'b1;
                state_d    = S_BR2;
            end
            S_BR2: begin
                sel_bus_2 = SEL2_MEM;
                load_pc   = 1'b1;
                state_d   = S_FET1;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_HALT;
        endcase
    end
endmodule

// File: tb/tb_spm_control_unit.sv
// tb_spm_control_unit: directed per-cycle checks of the control unit output vector
module tb_spm_control_unit;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] instruction = 8'h00;
    logic       zero = 1'b0;
    logic [3:0] load_r;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z, write, halted;
    logic [2:0] sel_bus_1;
    logic [1:0] sel_bus_2;
    logic [16:0] obs;
    int n_vec = 0;
    int n_err = 0;

    spm_control_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
        .load_r(load_r), .load_pc(load_pc), .inc_pc(inc_pc), .load_ir(load_ir),
        .load_add_r(load_add_r), .load_reg_y(load_reg_y), .load_reg_z(load_reg_z),
        .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2), .write(write), .halted(halted)
    );

    always #5 clk = ~clk;

    assign obs = {load_r, load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z,
                  sel_bus_1, sel_bus_2, write, halted};

    // Expected output vector, fields in the same order as obs
    function automatic logic [16:0] o(input logic [3:0] lr, input logic pc, input logic inc,
                                      input logic ir, input logic ar, input logic y, input logic z,
                                      input logic [2:0] s1, input logic [1:0] s2,
                                      input logic wr, input logic h);
        return {lr, pc, inc, ir, ar, y, z, s1, s2, wr, h};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic [16:0] v_fet1, v_fet2, v_addr, v_zero, v_halt;

    initial begin
        v_fet1 = o(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
        v_fet2 = o(4'b0000, 0, 1, 1, 0, 0, 0, 3'd0, 2'd2, 0, 0);
        v_addr = o(4'b0000, 0, 0, 0, 1, 0, 0, 3'd4, 2'd1, 0, 0);
        v_zero = '0;
        v_halt = o(4'b0000, 0, 0, 0, 0, 0, 0, 3'd0, 2'd0, 0, 1);

        @(negedge clk);
        @(negedge clk);
        check("reset_idle", obs, v_zero);
        rst = 1'b1;
        step(); check("first_fet1", obs, v_fet1);

        // NOP then SUB src=0 dest=1
        instruction = 8'h00;
        step(); check("nop_fet2", obs, v_fet2);
        step(); check("nop_dec", obs, v_zero);
        step(); check("nop_back_fet1", obs, v_fet1);
        instruction = 8'h21;
        step(); check("sub_fet2", obs, v_fet2);
        step(); check("sub_dec", obs, o(4'b0000, 0, 0, 0, 0, 1, 0, 3'd0, 2'd1, 0, 0));
        step(); check("sub_ex1", obs, o(4'b0010, 0, 0, 0, 0, 0, 1, 3'd1, 2'd0, 0, 0));
        step(); check("sub_fet1", obs, v_fet1);

        // RD dest=2
        instruction = 8'h52;
        step(); check("rd_fet2", obs, v_fet2);
        step(); check("rd_dec", obs, v_addr);
        step(); check("rd_rd1", obs, o(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        step(); check("rd_rd2", obs, o(4'b0100, 0, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
        step(); check("rd_fet1", obs, v_fet1);

        // BRZ taken
        instruction = 8'h80;
        zero = 1'b1;
        step(); check("brz1_fet2", obs, v_fet2);
        step(); check("brz1_dec", obs, v_addr);
        step(); check("brz1_br1", obs, o(4'b0000, 0, 0, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        step(); check("brz1_br2", obs, o(4'b0000, 1, 0, 0, 0, 0, 0, 3'd0, 2'd2, 0, 0));
        step(); check("brz1_fet1", obs, v_fet1);

        // BRZ untaken
        zero = 1'b0;
        step(); check("brz0_fet2", obs, v_fet2);
        step(); check("brz0_dec", obs, o(4'b0000, 0, 1, 0, 0, 0, 0, 3'd0, 2'd0, 0, 0));
        step(); check("brz0_fet1", obs, v_fet1);

        // WR src=3
        instruction = 8'h6C;
        step(); check("wr_fet2", obs, v_fet2);
        step(); check("wr_dec", obs, v_addr);
        step(); check("wr_wr1", obs, o(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        step(); check("wr_wr2", obs, o(4'b0000, 0, 0, 0, 0, 0, 0, 3'd3, 2'd0, 1, 0));
        step(); check("wr_fet1", obs, v_fet1);

        // Asynchronous reset in the middle of RD1
        instruction = 8'h52;
        step(); check("rst_rd_fet2", obs, v_fet2);
        step(); check("rst_rd_dec", obs, v_addr);
        step(); check("rst_rd_rd1", obs, o(4'b0000, 0, 1, 0, 1, 0, 0, 3'd0, 2'd2, 0, 0));
        rst = 1'b0;
        #1 check("rst_async_zero", obs, v_zero);
        @(negedge clk);
        check("rst_held_zero", obs, v_zero);
        rst = 1'b1;
        step(); check("rst_release_fet1", obs, v_fet1);

        // HLT, then an illegal opcode: both park in halt until reset
        for (int k = 0; k < 2; k++) begin
            instruction = k == 0 ? 8'hF0 : 8'hA0;
            step(); check("halt_fet2", obs, v_fet2);
            step(); check("halt_dec", obs, v_zero);
            for (int c = 0; c < 20; c++) begin
                step(); check("halt_hold", obs, v_halt);
            end
            rst = 1'b0;
            #1 check("halt_rst_zero", obs, v_zero);
            @(negedge clk);
            rst = 1'b1;
            step(); check("halt_rst_fet1", obs, v_fet1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
